// File: rtl/shift_stage_16bit_pkg.sv
// -----------------------------------------------------------------------------
// shift_stage_16bit_pkg
// Shared ALU definitions used by the shift stage and its downstream consumers:
//   - WIDTH / AMT_W    : datapath width (16) and shift-amount width (4)
//   - op_e             : shift opcodes (codes 101..111 all behave as PASS)
//   - result_t         : {data, carry, zero, neg}, reused by OUT, SKID and the
//                        downstream flag register
//   - make_result()    : attaches zero/neg flags to a data word and carry
// -----------------------------------------------------------------------------
package shift_stage_16bit_pkg;

  localparam int WIDTH = 16;
  localparam int AMT_W = $clog2(WIDTH);

  typedef enum logic [2:0] {
    OP_ROL  = 3'b000,
    OP_ROR  = 3'b001,
    OP_LSL  = 3'b010,
    OP_LSR  = 3'b011,
    OP_ASR  = 3'b100,
    OP_PASS = 3'b101
  } op_e;

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic             carry;
    logic             zero;
    logic             neg;
  } result_t;

  function automatic result_t make_result(input logic [WIDTH-1:0] data,
                                          input logic             carry);
    result_t r;
    r.data  = data;
    r.carry = carry;
    r.zero  = (data == '0);
    r.neg   = data[WIDTH-1];
    return r;
  endfunction

endpackage

// File: rtl/shift_stage_16bit_if.sv
// -----------------------------------------------------------------------------
// shift_stage_16bit_if
// Handshake bundle for the shift stage.
//   in_valid/in_ready  : operand dispatch handshake
//   in_data/amt/op     : operand, shift amount (0..15), opcode
//   out_valid/out_ready: result handshake toward the ALU result mux
//   out_data/carry/zero/neg : registered result and flags
// Modports: master = producer/consumer side (dispatch + result mux),
//           slave  = the shift stage itself.
// -----------------------------------------------------------------------------
interface shift_stage_16bit_if;
  import shift_stage_16bit_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [AMT_W-1:0] in_amt;
  logic [2:0]       in_op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_carry;
  logic             out_zero;
  logic             out_neg;

  modport master (
    output in_valid, in_data, in_amt, in_op, out_ready,
    input  in_ready, out_valid, out_data, out_carry, out_zero, out_neg
  );

  modport slave (
    input  in_valid, in_data, in_amt, in_op, out_ready,
    output in_ready, out_valid, out_data, out_carry, out_zero, out_neg
  );

endinterface

// File: rtl/shift_stage_16bit_core.sv
// -----------------------------------------------------------------------------
// shift_core_16bit
// Combinational shift/rotate core.
//   in_data : operand
//   in_amt  : shift amount 0..15
//   in_op   : opcode (ROL, ROR, LSL, LSR, ASR, anything else PASS)
//   res     : result word with carry (last bit shifted out), zero and neg
// An amount of zero always yields the unchanged operand with carry cleared.
// -----------------------------------------------------------------------------
module shift_core_16bit
  import shift_stage_16bit_pkg::*;
(
  input  logic [WIDTH-1:0] in_data,
  input  logic [AMT_W-1:0] in_amt,
  input  logic [2:0]       in_op,
  output result_t          res
);

  // Rotates are windows into the operand concatenated with itself.
  logic [2*WIDTH-1:0]     dbl;
  logic [AMT_W:0]         rol_hi;
  logic [AMT_W:0]         ror_hi;
  logic signed [WIDTH-1:0] sdata;
  logic signed [WIDTH-1:0] asr_s;
  logic [AMT_W-1:0]       lidx;
  logic [AMT_W-1:0]       ridx;
  logic [WIDTH-1:0]       data;
  logic                   carry;

  assign dbl    = {in_data, in_data};
  assign rol_hi = (AMT_W+1)'(2*WIDTH-1) - {1'b0, in_amt};
  assign ror_hi = (AMT_W+1)'(WIDTH-1) + {1'b0, in_amt};
  assign sdata  = in_data;
  assign asr_s  = sdata >>> in_amt;

  // Bit that leaves the word last: WIDTH-n for left moves (mod WIDTH), n-1 for right.
  assign lidx = AMT_W'(0) - in_amt;
  assign ridx = in_amt - AMT_W'(1);

  always_comb begin
    data  = in_data;
    carry = 1'b0;
    case (in_op)
      OP_ROL: begin
        data  = dbl[rol_hi -: WIDTH];
        carry = in_data[lidx];
      end
      OP_ROR: begin
        data  = dbl[ror_hi -: WIDTH];
        carry = in_data[ridx];
      end
      OP_LSL: begin
        data  = in_data << in_amt;
        carry = in_data[lidx];
      end
      OP_LSR: begin
        data  = in_data >> in_amt;
        carry = in_data[ridx];
      end
      OP_ASR: begin
        data  = asr_s;
        carry = in_data[ridx];
      end
      default: begin
        data  = in_data;
        carry = 1'b0;
      end
    endcase
    if (in_amt == '0) carry = 1'b0;
  end

  assign res = make_result(data, carry);

endmodule

// File: rtl/shift_stage_16bit.sv
// -----------------------------------------------------------------------------
// shift_stage_16bit
// Registered shift/rotate execution stage with a two-entry skid buffer.
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset; clears both entries and all outputs
//   bus  : shift_stage_16bit_if.slave (operand in, result + flags out)
// A result accepted at edge k is presented after edge k. OUT feeds the
// outputs directly; SKID catches one extra result while OUT is stalled.
// in_ready depends only on SKID occupancy and rst, never on out_ready.
// -----------------------------------------------------------------------------
module shift_stage_16bit
  import shift_stage_16bit_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  shift_stage_16bit_if.slave    bus
);

  result_t res_p0;
  result_t out_p1;
  result_t skid_p1;
  logic    vld_p1;
  logic    skid_vld_p1;
  logic    accept_p0;
  logic    drain_p1;
  logic    in_ready_p0;

  // ---- stage p0: operand decode and combinational shift ----
  shift_core_16bit u_core (
    .in_data (bus.in_data),
    .in_amt  (bus.in_amt),
    .in_op   (bus.in_op),
    .res     (res_p0)
  );

  assign in_ready_p0 = ~skid_vld_p1 & ~rst;
  assign accept_p0   = bus.in_valid & in_ready_p0;
  assign drain_p1    = vld_p1 & bus.out_ready;

  // ---- stage p1: OUT / SKID registers ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_p1      <= '0;
      skid_p1     <= '0;
      vld_p1      <= 1'b0;
      skid_vld_p1 <= 1'b0;
    end else if (~vld_p1 | drain_p1) begin
      // OUT is free this edge: the older SKID entry has priority. An accept
      // cannot coincide with a full SKID because in_ready is low then.
      if (skid_vld_p1) begin
        out_p1      <= skid_p1;
        vld_p1      <= 1'b1;
        skid_vld_p1 <= 1'b0;
      end else if (accept_p0) begin
        out_p1 <= res_p0;
        vld_p1 <= 1'b1;
      end else begin
        vld_p1 <= 1'b0;
      end
    end else if (accept_p0) begin
      skid_p1     <= res_p0;
      skid_vld_p1 <= 1'b1;
    end
  end

  assign bus.in_ready  = in_ready_p0;
  assign bus.out_valid = vld_p1;
  assign bus.out_data  = out_p1.data;
  assign bus.out_carry = out_p1.carry;
  assign bus.out_zero  = out_p1.zero;
  assign bus.out_neg   = out_p1.neg;

endmodule

// File: tb/tb_shift_stage_16bit.sv
// -----------------------------------------------------------------------------
// tb_shift_stage_16bit
// Self-checking bench for shift_stage_16bit: directed cases, backpressure,
// asynchronous reset mid-operation and a randomized stream checked against a
// bit-serial reference model.
// -----------------------------------------------------------------------------
module tb_shift_stage_16bit;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_pass;

  shift_stage_16bit_if bus ();

  shift_stage_16bit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp)
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    else
      n_pass++;
  endtask

  // Reference: shift one bit at a time, carry is whatever fell off last.
  function automatic logic [18:0] ref_model(input logic [2:0] op, input logic [3:0] n,
                                            input logic [15:0] din);
    logic [15:0] d;
    logic        c;
    d = din;
    c = 1'b0;
    for (int i = 0; i < int'(n); i++) begin
      case (op)
        3'd0: begin c = d[15]; d = {d[14:0], d[15]}; end
        3'd1: begin c = d[0];  d = {d[0], d[15:1]};  end
        3'd2: begin c = d[15]; d = {d[14:0], 1'b0};  end
        3'd3: begin c = d[0];  d = {1'b0, d[15:1]};  end
        3'd4: begin c = d[0];  d = {d[15], d[15:1]}; end
        default: begin c = 1'b0; end
      endcase
    end
    return {d, c, (d == 16'h0000), d[15]};
  endfunction

  function automatic logic [31:0] outs();
    return 32'({bus.out_data, bus.out_carry, bus.out_zero, bus.out_neg});
  endfunction

  // Stream monitor: transfers are judged at the negedge before the edge that completes them.
  logic [18:0] exp_q[$];
  logic        mon_en;
  logic        acc_seen;
  int          n_acc;
  int          n_del;

  always @(negedge clk) begin
    acc_seen = bus.in_valid && bus.in_ready;
    if (mon_en) begin
      if (bus.out_valid && bus.out_ready) begin
        n_del++;
        if (exp_q.size() == 0)
          chk("stream_underflow", 32'd1, 32'd0);
        else
          chk("stream_item", outs(), 32'(exp_q.pop_front()));
      end
      if (acc_seen) begin
        n_acc++;
        exp_q.push_back(ref_model(bus.in_op, bus.in_amt, bus.in_data));
      end
    end
  end

  task automatic drive(input logic v, input logic [2:0] op, input logic [3:0] amt,
                       input logic [15:0] d);
    bus.in_valid = v;
    bus.in_op    = op;
    bus.in_amt   = amt;
    bus.in_data  = d;
  endtask

  // Called at posedge+1 with the stage idle; checks the result one edge later.
  task automatic do_one(input string tag, input logic [2:0] op, input logic [3:0] amt,
                        input logic [15:0] d, input logic [18:0] exp);
    bus.out_ready = 1'b1;
    drive(1'b1, op, amt, d);
    @(posedge clk); #1;
    drive(1'b0, 3'd0, 4'd0, 16'h0);
    chk({tag, "_vld"}, 32'(bus.out_valid), 32'd1);
    chk(tag, outs(), 32'(exp));
    @(posedge clk); #1;
  endtask

  initial begin
    int sent;
    int cyc;
    n_chk   = 0;
    n_pass  = 0;
    mon_en  = 1'b0;
    n_acc   = 0;
    n_del   = 0;
    rst     = 1'b1;
    bus.out_ready = 1'b0;
    drive(1'b0, 3'd0, 4'd0, 16'h0);

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
    chk("rst_outs", outs(), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_in_ready", 32'(bus.in_ready), 32'd1);

    // Directed cases
    do_one("rol_8001_1", 3'd0, 4'd1,  16'h8001, {16'h0003, 1'b1, 1'b0, 1'b0});
    do_one("ror_0001_1", 3'd1, 4'd1,  16'h0001, {16'h8000, 1'b1, 1'b0, 1'b1});
    do_one("asr_8000_15", 3'd4, 4'd15, 16'h8000, {16'hFFFF, 1'b0, 1'b0, 1'b1});
    do_one("lsl_8000_1", 3'd2, 4'd1,  16'h8000, {16'h0000, 1'b1, 1'b1, 1'b0});
    for (int op = 0; op < 8; op++)
      do_one($sformatf("n0_op%0d", op), 3'(op), 4'd0, 16'hA5A5, {16'hA5A5, 1'b0, 1'b0, 1'b1});

    // Backpressure: A, B, C with out_ready low
    bus.out_ready = 1'b0;
    drive(1'b1, 3'd5, 4'd0, 16'h000A);
    @(posedge clk); #1;
    drive(1'b1, 3'd5, 4'd0, 16'h000B);
    @(posedge clk); #1;
    chk("bp_in_ready_low", 32'(bus.in_ready), 32'd0);
    chk("bp_out_a", 32'(bus.out_data), 32'h000A);
    drive(1'b1, 3'd5, 4'd0, 16'h000C);
    @(posedge clk); #1;
    chk("bp_c_held", 32'(bus.in_ready), 32'd0);
    chk("bp_out_a_stable", 32'(bus.out_data), 32'h000A);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_out_b", 32'(bus.out_data), 32'h000B);
    chk("bp_in_ready_up", 32'(bus.in_ready), 32'd1);
    @(posedge clk); #1;
    drive(1'b0, 3'd0, 4'd0, 16'h0);
    chk("bp_out_c", 32'(bus.out_data), 32'h000C);
    chk("bp_out_c_vld", 32'(bus.out_valid), 32'd1);
    @(posedge clk); #1;
    chk("bp_empty", 32'(bus.out_valid), 32'd0);

    // Asynchronous reset with OUT and SKID full
    bus.out_ready = 1'b0;
    drive(1'b1, 3'd0, 4'd3, 16'h1234);
    @(posedge clk); #1;
    drive(1'b1, 3'd2, 4'd2, 16'h4321);
    @(posedge clk); #1;
    drive(1'b0, 3'd0, 4'd0, 16'h0);
    chk("mid_full", 32'({bus.out_valid, bus.in_ready}), 32'b10);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_vld", 32'(bus.out_valid), 32'd0);
    chk("async_rst_outs", outs(), 32'd0);
    chk("async_rst_in_ready", 32'(bus.in_ready), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("rel_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rel_out_valid", 32'(bus.out_valid), 32'd0);
    do_one("lsr_00f0_4", 3'd3, 4'd4, 16'h00F0, {16'h000F, 1'b0, 1'b0, 1'b0});

    // Randomized stream with random backpressure
    mon_en = 1'b1;
    sent   = 0;
    cyc    = 0;
    @(posedge clk); #1;
    while (sent < 100 && cyc < 4000) begin
      if (acc_seen) sent++;
      if (sent >= 100)
        drive(1'b0, 3'd0, 4'd0, 16'h0);
      else if (!bus.in_valid || acc_seen)
        drive(($urandom % 4) != 0, 3'($urandom % 8), 4'($urandom % 16), 16'($urandom));
      bus.out_ready = 1'($urandom % 2);
      @(posedge clk); #1;
      cyc++;
    end
    if (sent < 100) chk("stream_send_timeout", 32'(sent), 32'd100);
    drive(1'b0, 3'd0, 4'd0, 16'h0);
    bus.out_ready = 1'b1;
    cyc = 0;
    while ((exp_q.size() != 0 || bus.out_valid) && cyc < 50) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("stream_drain", 32'(exp_q.size()), 32'd0);
    chk("stream_count", 32'(n_del), 32'(n_acc));
    chk("stream_accepted", 32'(n_acc), 32'd100);
    mon_en = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/shift_stage_16bit.md
# shift_stage_16bit

Registered shift/rotate execution stage for the 16-bit ALU.
- Accepts one operand, a 4-bit amount and a shift opcode per cycle over a valid/ready handshake.
- Computes rotate-left/right, logical shifts and arithmetic right shift, plus carry/zero/negative flags.
- Presents the result one cycle later through a two-entry skid buffer, sitting between operand dispatch and the ALU result mux/flag register.

## Interface
- WIDTH, 16, data width; fixed at 16, amount width is clog2(WIDTH)=4.
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operand/op/amount valid.
- in_ready  output  1  stage can accept this cycle.
- in_data  input  16  operand.
- in_amt  input  4  shift amount 0..15.
- in_op  input  3  000 ROL, 001 ROR, 010 LSL, 011 LSR, 100 ASR, 101..111 PASS.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- out_data  output  16  result.
- out_carry  output  1  last bit shifted or rotated out.
- out_zero  output  1  out_data == 0.
- out_neg  output  1  out_data[15].

## Operation
- Transfer in: in_valid & in_ready at a clock edge. Transfer out: out_valid & out_ready at a clock edge.
- Result rules for amount n:
  - ROL: rotate left by n.
  - ROR: rotate right by n, equal to ROL by (16-n) mod 16.
  - LSL: zero-fill low bits.
  - LSR: zero-fill high bits.
  - ASR: fill high bits with in_data[15].
  - PASS: result = in_data, carry 0.
- Carry rules:
  - n = 0: carry 0 for every op and data is unchanged.
  - ROL and LSL: carry = in_data[16-n].
  - ROR, LSR and ASR: carry = in_data[n-1].
- zero and neg are computed from the final result and registered together with it.
- Storage is an output register (OUT) plus one skid register (SKID), each holding data, carry, zero, neg and a valid bit.
  - Accept while OUT is empty or being drained: the result goes to OUT.
  - Accept while OUT is full and out_ready is low: the result goes to SKID.
  - When OUT drains and SKID is valid: SKID moves to OUT in the same edge, and SKID is emptied unless a new accept refills it.
- in_ready = ~SKID.valid & ~rst. It is a function of registered state only, with no combinational path from out_ready.
- Ordering is strict FIFO: no drops, no duplicates.
- Simultaneous drain of OUT with an accept while SKID is empty: the new result loads OUT directly.
- Reset (any time, including mid-transfer):
  - OUT.valid and SKID.valid clear immediately.
  - out_valid=0, out_data=0, out_carry=0, out_zero=0, out_neg=0, in_ready=0.
  - in_ready=1 from the first clock edge after rst deasserts.
  - In-flight items are discarded.

## Timing
- Latency: accept at edge k gives out_valid=1 with the result after edge k.
- Throughput: 1 result per cycle while out_ready is held high.
- Backpressure:
  - With out_ready low, at most 2 items are held.
  - in_ready falls in the cycle after the second accept.
  - in_ready rises in the cycle after the first drain.
- Outputs are stable while out_valid=1 and out_ready=0.
- All outputs are registered, except in_ready, which is a single gate from flops and rst.

## Structure
- Shared ALU package:
  - opcode constants OP_ROL/OP_ROR/OP_LSL/OP_LSR/OP_ASR/OP_PASS.
  - WIDTH=16 and AMT_W=4.
  - A result struct {data, carry, zero, neg} reused by OUT, SKID and the downstream flag register.
- Sub-module shift_core_16bit (combinational): in_data, in_amt, in_op -> result struct.
- shift_stage_16bit holds only the handshake, OUT/SKID registers and reset logic.

## Test plan
- ROL 0x8001 n=1 -> 0x0003, carry=1, zero=0, neg=0.
- ROR 0x0001 n=1 -> 0x8000, carry=1, neg=1.
- ASR 0x8000 n=15 -> 0xFFFF, carry=0, neg=1.
- LSL 0x8000 n=1 -> 0x0000, carry=1, zero=1.
- Every op with n=0 on 0xA5A5 -> 0xA5A5, carry=0.
- Backpressure:
  - Stimulus: out_ready=0, push A, B, C back-to-back.
  - A lands in OUT and B in SKID; in_ready=0 and C is held.
  - Raise out_ready: A, B, C emerge on consecutive cycles in order.
- Reset mid-operation:
  - Stimulus: assert rst asynchronously between edges with OUT and SKID full.
  - out_valid=0 and outputs are 0 without waiting for a clock edge.
  - After release, one push of LSR 0x00F0 n=4 -> 0x000F, carry=0, one cycle later.
- Streaming: 100 random ops with out_ready toggling randomly -> every result matches the reference model in order, and the accepted count equals the delivered count.
